alu_decoder_md: RTL and testbench
=================================

// Module: alu_decoder_md
// PURPOSE
//  Next-generation ALU control for the RV32 core. Decodes full RV32I ALU ops (I/R-type incl. shifts,
//  XOR, SLTU) to a 4-bit ALUControl and adds the M extension through an iterative mul/div sequencer.
//  Sits between the main decoder and the ALU/writeback mux; on a MUL/DIV it stalls the PC/regfile
//  until the result is ready. Non-M instructions stay single-cycle: ALUControl is purely combinational.
// PARAMETERS
//  XLEN      32  operand/result width (power of 2, >=8)
//  ENABLE_M  1   1: decode M ops via sequencer; 0: M encodings flag illegal, sequencer never starts
// PORTS
//  clk          in   1     single clock, rising edge
//  reset        in   1     synchronous, active-high
//  ALUOp        in   2     00 add (lw/sw), 01 sub (branch), 10 R/I ALU, 11 reserved
//  funct3       in   3     Instr[14:12]
//  funct7_5     in   1     Instr[30]
//  funct7_0     in   1     Instr[25]; with op_5=1 and funct7_5=0 selects M extension
//  op_5         in   1     Instr[5]; 1 = R-type, 0 = I-type
//  instr_valid  in   1     current instruction is live (0 during bubbles)
//  SrcA, SrcB   in   XLEN  mul/div operands (rs1, rs2)
//  ALUControl   out  4     ALU op select (combinational)
//  illegal      out  1     unsupported ALUOp/funct combination (combinational)
//  stall        out  1     hold PC/regfile write this cycle
//  md_sel       out  1     writeback takes md_result instead of ALU result
//  md_result    out  XLEN  mul/div result, valid when md_sel=1
// BEHAVIOUR
//  Encoding: ADD 0000 SUB 0001 AND 0010 OR 0011 XOR 0100 SLT 0101 SLTU 0110 SLL 0111 SRL 1000 SRA 1001.
//  ALUOp 00->ADD, 01->SUB regardless of funct. ALUOp 10: f3 000 ADD, or SUB iff op_5&funct7_5;
//   001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA if funct7_5 else SRL; 110 OR; 111 AND.
//  ALUOp 11, or R-type with funct7_0=1 while ENABLE_M=0 -> illegal=1, ALUControl=0000. Never drive X.
//  M op = ALUOp==10 & op_5 & funct7_0 & !funct7_5 & ENABLE_M. f3: 000 MUL 001 MULH 010 MULHSU
//   011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU. ALUControl=0000 during M ops (don't-care to ALU).
//  FSM states IDLE, BUSY, DONE. Reset: state IDLE, counter 0, md_result 0, stall 0, md_sel 0.
//  IDLE: M op & instr_valid -> latch |operands|, signs, f3; stall=1 (combinational) that cycle;
//   go BUSY with count=0, or DONE directly for special cases below. Otherwise stall=0.
//  BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle; stall=1; after XLEN steps
//   (count==XLEN-1) apply sign fix-up, register md_result, go DONE.
//  DONE: stall=0, md_sel=1, md_result stable; core commits this cycle; next cycle IDLE.
//   DONE never re-accepts: same instruction is not restarted.
//  Latency: accept cycle T, DONE at T+XLEN+1 (XLEN+1 stall cycles). Special cases: DONE at T+1.
//  Special cases (RISC-V spec): div by 0 -> quotient all-ones (DIV and DIVU), remainder = SrcA;
//   DIV/REM with SrcA=-2^(XLEN-1), SrcB=-1 -> quotient = SrcA, remainder 0.
//  Signed ops: operate on magnitudes; MUL* product 2*XLEN bits, negate if signs differ; MULHSU
//   treats SrcB unsigned. Quotient sign = sA^sB, remainder sign = sA. MUL returns low half, MULH* high.
//  instr_valid=0 in IDLE: no start. Operand inputs ignored after accept (changes mid-op harmless).
//  reset mid-operation: abort, return to reset values next edge; no partial result visible.
//  ALUOp==11 while BUSY: sequencer unaffected (inputs are held by stall anyway).
// STRUCTURE
//  alu_pkg: ALUControl localparams (ALU_ADD..ALU_SRA), ALUOp codes, M funct3 codes, FSM state codes.
//  Sub-module md_iter_core: XLEN-wide iterative mul/div datapath (acc/quotient regs, step enable,
//   mode in, raw result out); decode, special-case detect, sign fix-up and FSM stay in the top.
// TESTING
//  ALUOp=10,op_5=1,funct7_5=1,f3=000 -> ALUControl=0001; op_5=0 same funct -> 0000; f3=101,f7_5=1 -> 1001.
//  MUL 7*-3 (XLEN=32): stall high 33 cycles, DONE md_result=0xFFFFFFEB, md_sel=1 one cycle.
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
//  DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF in 2 cycles, REMU 5/0 -> 5.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, DONE at T+1.
//  Assert reset at BUSY count 10 -> next cycle stall=0, md_sel=0, md_result=0; new DIV completes ok.

Source files
------------

// File: rtl/alu_decoder_md_pkg.sv
// Shared encodings for the RV32 ALU decoder and its M-extension sequencer:
// ALU control codes, ALUOp codes, funct3 meanings and sequencer states.
package alu_decoder_md_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_SUB = 2'b01;
   localparam logic [1:0] ALUOP_RI  = 2'b10;
   localparam logic [1:0] ALUOP_RSV = 2'b11;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   function automatic logic md_src_a_signed(input logic [2:0] f3);
      case (f3)
         MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM: return 1'b1;
         default:                                    return 1'b0;
      endcase
   endfunction

   // MULHSU takes rs2 as unsigned, so it is absent here.
   function automatic logic md_src_b_signed(input logic [2:0] f3);
      case (f3)
         MD_MUL, MD_MULH, MD_DIV, MD_REM: return 1'b1;
         default:                         return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder_md_md_iter_core.sv
// Unsigned iterative multiply/divide datapath: one shift-add or restoring
// subtract step per enabled cycle; res_hi/res_lo show the post-step values.
module md_iter_core #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            step,
   input  logic            is_div,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic [XLEN-1:0] res_hi,
   output logic [XLEN-1:0] res_lo
);

   logic [XLEN-1:0] hi_q;
   logic [XLEN-1:0] lo_q;
   logic [XLEN-1:0] b_q;

   logic [XLEN:0]   mul_sum;
   logic [XLEN-1:0] mul_hi;
   logic [XLEN-1:0] mul_lo;
   logic [XLEN:0]   div_shift;
   logic [XLEN:0]   div_diff;
   logic [XLEN-1:0] div_hi;
   logic [XLEN-1:0] div_lo;

   // hi:lo is the running product (mul) or remainder:quotient pair (div).
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
      mul_hi    = mul_sum[XLEN:1];
      mul_lo    = {mul_sum[0], lo_q[XLEN-1:1]};
      div_shift = {hi_q, lo_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, b_q};
      if (!div_diff[XLEN]) begin
         div_hi = div_diff[XLEN-1:0];
         div_lo = {lo_q[XLEN-2:0], 1'b1};
      end else begin
         div_hi = div_shift[XLEN-1:0];
         div_lo = {lo_q[XLEN-2:0], 1'b0};
      end
      res_hi = is_div ? div_hi : mul_hi;
      res_lo = is_div ? div_lo : mul_lo;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q <= '0;
         lo_q <= '0;
         b_q  <= '0;
      end else if (load) begin
         hi_q <= '0;
         lo_q <= op_a;
         b_q  <= op_b;
      end else if (step) begin
         hi_q <= res_hi;
         lo_q <= res_lo;
      end
   end

endmodule

// File: rtl/alu_decoder_md.sv
// RV32I ALU control decoder with an iterative M-extension sequencer that
// stalls the core while a multiply or divide is in flight.
module alu_decoder_md
   import alu_decoder_md_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [1:0]      ALUOp,
   input  logic [2:0]      funct3,
   input  logic            funct7_5,
   input  logic            funct7_0,
   input  logic            op_5,
   input  logic            instr_valid,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   output logic [3:0]      ALUControl,
   output logic            illegal,
   output logic            stall,
   output logic            md_sel,
   output logic [XLEN-1:0] md_result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e state, state_nxt;

   logic            m_op;
   logic            accept;
   logic            sa;
   logic            sb;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic            special_hit;
   logic [XLEN-1:0] special_result;
   logic [CW-1:0]   count;
   logic            last_step;
   logic [2:0]      f3_q;
   logic            sign_a_q;
   logic            sign_b_q;
   logic [XLEN-1:0] core_hi;
   logic [XLEN-1:0] core_lo;
   logic [2*XLEN-1:0] product;
   logic [2*XLEN-1:0] product_fix;
   logic [XLEN-1:0] quot_fix;
   logic [XLEN-1:0] rem_fix;
   logic [XLEN-1:0] fixed_result;

   assign m_op = ENABLE_M && (ALUOp == ALUOP_RI) && op_5 && funct7_0 && !funct7_5;

   always_comb begin
      ALUControl = ALU_ADD;
      illegal    = 1'b0;
      case (ALUOp)
         ALUOP_ADD: ALUControl = ALU_ADD;
         ALUOP_SUB: ALUControl = ALU_SUB;
         ALUOP_RI: begin
            if (op_5 && funct7_0 && !ENABLE_M) begin
               illegal = 1'b1;
            end else if (!m_op) begin
               case (funct3)
                  F3_ADD:  ALUControl = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
                  F3_SLL:  ALUControl = ALU_SLL;
                  F3_SLT:  ALUControl = ALU_SLT;
                  F3_SLTU: ALUControl = ALU_SLTU;
                  F3_XOR:  ALUControl = ALU_XOR;
                  F3_SR:   ALUControl = funct7_5 ? ALU_SRA : ALU_SRL;
                  F3_OR:   ALUControl = ALU_OR;
                  F3_AND:  ALUControl = ALU_AND;
                  default: ALUControl = ALU_ADD;
               endcase
            end
         end
         ALUOP_RSV: illegal = 1'b1;
         default:   illegal = 1'b1;
      endcase
   end

   // Operand conditioning and RISC-V special cases, evaluated at accept time.
   always_comb begin
      accept         = (state == MD_IDLE) && m_op && instr_valid && !reset;
      sa             = md_src_a_signed(funct3) && SrcA[XLEN-1];
      sb             = md_src_b_signed(funct3) && SrcB[XLEN-1];
      mag_a          = sa ? (~SrcA + 1'b1) : SrcA;
      mag_b          = sb ? (~SrcB + 1'b1) : SrcB;
      special_hit    = 1'b0;
      special_result = '0;
      if (funct3[2] && (SrcB == '0)) begin
         special_hit    = 1'b1;
         special_result = funct3[1] ? SrcA : {XLEN{1'b1}};
      end else if (funct3[2] && !funct3[0] && (SrcA == MIN_NEG) && (SrcB == {XLEN{1'b1}})) begin
         special_hit    = 1'b1;
         special_result = funct3[1] ? '0 : SrcA;
      end
   end

   md_iter_core #(.XLEN(XLEN)) u_core (
      .clk    (clk),
      .reset  (reset),
      .load   (accept),
      .step   (state == MD_BUSY),
      .is_div (f3_q[2]),
      .op_a   (mag_a),
      .op_b   (mag_b),
      .res_hi (core_hi),
      .res_lo (core_lo)
   );

   assign last_step = (count == LAST_STEP);

   always_comb begin
      product      = {core_hi, core_lo};
      product_fix  = (sign_a_q ^ sign_b_q) ? (~product + 1'b1) : product;
      quot_fix     = (sign_a_q ^ sign_b_q) ? (~core_lo + 1'b1) : core_lo;
      rem_fix      = sign_a_q ? (~core_hi + 1'b1) : core_hi;
      if (f3_q[2]) begin
         fixed_result = f3_q[1] ? rem_fix : quot_fix;
      end else begin
         fixed_result = (f3_q == MD_MUL) ? product_fix[XLEN-1:0] : product_fix[2*XLEN-1:XLEN];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= MD_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MD_IDLE: if (accept) state_nxt = special_hit ? MD_DONE : MD_BUSY;
         MD_BUSY: if (last_step) state_nxt = MD_DONE;
         MD_DONE: state_nxt = MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
   end

   always_comb begin
      stall  = accept || (state == MD_BUSY);
      md_sel = (state == MD_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= '0;
         md_result <= '0;
         f3_q      <= '0;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
      end else if (accept) begin
         f3_q     <= funct3;
         sign_a_q <= sa;
         sign_b_q <= sb;
         count    <= '0;
         if (special_hit) md_result <= special_result;
      end else if (state == MD_BUSY) begin
         count <= count + 1'b1;
         if (last_step) md_result <= fixed_result;
      end
   end

endmodule

// File: tb/tb_alu_decoder_md.sv
// Directed bench for alu_decoder_md: ALU decode table, M-extension results
// and latency, special cases, mid-operation reset and the ENABLE_M=0 build.
module tb_alu_decoder_md;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  ALUOp;
   logic [2:0]  funct3;
   logic        funct7_5;
   logic        funct7_0;
   logic        op_5;
   logic        instr_valid;
   logic [31:0] SrcA;
   logic [31:0] SrcB;

   logic [3:0]  ALUControl;
   logic        illegal;
   logic        stall;
   logic        md_sel;
   logic [31:0] md_result;

   logic [3:0]  alu_ctl_nm;
   logic        illegal_nm;
   logic        stall_nm;
   logic        md_sel_nm;
   logic [31:0] md_result_nm;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_decoder_md #(.XLEN(32), .ENABLE_M(1'b1)) dut (
      .clk(clk), .reset(reset), .ALUOp(ALUOp), .funct3(funct3),
      .funct7_5(funct7_5), .funct7_0(funct7_0), .op_5(op_5),
      .instr_valid(instr_valid), .SrcA(SrcA), .SrcB(SrcB),
      .ALUControl(ALUControl), .illegal(illegal), .stall(stall),
      .md_sel(md_sel), .md_result(md_result)
   );

   alu_decoder_md #(.XLEN(32), .ENABLE_M(1'b0)) dut_nm (
      .clk(clk), .reset(reset), .ALUOp(ALUOp), .funct3(funct3),
      .funct7_5(funct7_5), .funct7_0(funct7_0), .op_5(op_5),
      .instr_valid(instr_valid), .SrcA(SrcA), .SrcB(SrcB),
      .ALUControl(alu_ctl_nm), .illegal(illegal_nm), .stall(stall_nm),
      .md_sel(md_sel_nm), .md_result(md_result_nm)
   );

   task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3,
                                input logic f75, input logic f70, input logic o5,
                                input logic valid, input logic [31:0] a, input logic [31:0] b);
      ALUOp       = op;
      funct3      = f3;
      funct7_5    = f75;
      funct7_0    = f70;
      op_5        = o5;
      instr_valid = valid;
      SrcA        = a;
      SrcB        = b;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Issues one M op held until the stall drops, then checks stall count and result.
   task automatic runMd(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_stalls);
      int stalls;
      int guard;
      stalls = 0;
      guard  = 0;
      applyStimulus(2'b10, f3, 1'b0, 1'b1, 1'b1, 1'b1, a, b);
      #1;
      while (stall === 1'b1 && guard < 100) begin
         stalls++;
         guard++;
         @(posedge clk);
         #2;
      end
      checkOutput({tag, " stalls"}, 32'(stalls), 32'(exp_stalls));
      checkOutput({tag, " md_sel"}, {31'b0, md_sel}, 32'd1);
      checkOutput({tag, " result"}, md_result, exp_res);
      instr_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput({tag, " md_sel clear"}, {31'b0, md_sel}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset stall", {31'b0, stall}, 32'd0);
      checkOutput("reset md_sel", {31'b0, md_sel}, 32'd0);
      checkOutput("reset md_result", md_result, 32'h0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Combinational decode with instr_valid low so nothing starts.
      applyStimulus(2'b00, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0); #1;
      checkOutput("aluop00 add", {28'b0, ALUControl}, 32'h0);
      applyStimulus(2'b01, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0); #1;
      checkOutput("aluop01 sub", {28'b0, ALUControl}, 32'h1);
      applyStimulus(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0); #1;
      checkOutput("R sub", {28'b0, ALUControl}, 32'h1);
      applyStimulus(2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
      checkOutput("I addi", {28'b0, ALUControl}, 32'h0);
      applyStimulus(2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0); #1;
      checkOutput("sra", {28'b0, ALUControl}, 32'h9);
      applyStimulus(2'b10, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
      checkOutput("srl", {28'b0, ALUControl}, 32'h8);
      applyStimulus(2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0); #1;
      checkOutput("sll", {28'b0, ALUControl}, 32'h7);
      applyStimulus(2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0); #1;
      checkOutput("slt", {28'b0, ALUControl}, 32'h5);
      applyStimulus(2'b10, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
      checkOutput("sltu", {28'b0, ALUControl}, 32'h6);
      applyStimulus(2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0); #1;
      checkOutput("xor", {28'b0, ALUControl}, 32'h4);
      applyStimulus(2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0); #1;
      checkOutput("or", {28'b0, ALUControl}, 32'h3);
      applyStimulus(2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0); #1;
      checkOutput("and", {28'b0, ALUControl}, 32'h2);
      checkOutput("and legal", {31'b0, illegal}, 32'd0);
      applyStimulus(2'b11, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0); #1;
      checkOutput("aluop11 illegal", {31'b0, illegal}, 32'd1);
      checkOutput("aluop11 ctl", {28'b0, ALUControl}, 32'h0);
      applyStimulus(2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0); #1;
      checkOutput("M remu ctl", {28'b0, ALUControl}, 32'h0);
      checkOutput("M legal", {31'b0, illegal}, 32'd0);
      @(posedge clk); #1;
      checkOutput("no start invalid", {31'b0, stall}, 32'd0);

      runMd("MUL 7*-3", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
      runMd("MULHU", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      runMd("MULH", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
      runMd("MULHSU", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      runMd("DIV -7/2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
      runMd("REM -7/2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
      runMd("DIVU 5/0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
      runMd("REMU 5/0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
      runMd("REM -7/0", 3'b110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1);
      runMd("DIV ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      runMd("REM ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
      runMd("REMU 100/7", 3'b111, 32'd100, 32'd7, 32'd2, 33);

      // Abort a DIV when its step counter reaches 10.
      applyStimulus(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 1'b1, 32'd1000, 32'd3);
      @(posedge clk);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("busy before abort", {31'b0, stall}, 32'd1);
      reset       = 1'b1;
      instr_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("abort stall", {31'b0, stall}, 32'd0);
      checkOutput("abort md_sel", {31'b0, md_sel}, 32'd0);
      checkOutput("abort md_result", md_result, 32'h0);
      @(posedge clk);
      #1;
      runMd("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 33);

      // Build without the M extension flags M encodings and never stalls.
      applyStimulus(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 32'd3, 32'd4);
      #1;
      checkOutput("noM illegal", {31'b0, illegal_nm}, 32'd1);
      checkOutput("noM ctl", {28'b0, alu_ctl_nm}, 32'h0);
      checkOutput("M build legal", {31'b0, illegal}, 32'd0);
      @(posedge clk);
      #2;
      checkOutput("noM stall", {31'b0, stall_nm}, 32'd0);
      checkOutput("noM md_sel", {31'b0, md_sel_nm}, 32'd0);
      applyStimulus(2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
      #1;
      checkOutput("noM xor", {28'b0, alu_ctl_nm}, 32'h4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
